// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and helpers for the load/store unit.
// FSM state encodings, RV32I funct3 size/sign codes, lane widths and
// legality helpers used by load_store_unit and lsu_lane_align.
package lsu_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Lane geometry of a 32-bit word: four byte lanes, two halfword lanes.
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    // Stores only come in signed-size flavours; loads also allow bu/hu.
    function automatic logic legalFunct3(input logic isStore, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!isStore) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // Halfwords need an even address, words need a word-aligned address.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        if ((f3 == F3_H) || (f3 == F3_HU)) begin
            bad = lane[0];
        end else if (f3 == F3_W) begin
            bad = (lane != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational byte/halfword lane handling.
// Load side extracts the addressed lane and sign/zero extends it; store
// side replaces the addressed lane of the old memory word with new data.
// Halfword lanes use lane_i[1] only, words ignore lane_i entirely.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] loadData_o,
    output logic [31:0] mergeData_o
);

    logic [4:0]  byteShift;
    logic [4:0]  halfShift;
    logic [31:0] byteWord;
    logic [31:0] halfWord;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic [31:0] byteMask;
    logic [31:0] halfMask;

    assign byteShift = {lane_i, 3'b000};
    assign halfShift = {lane_i[1], 4'b0000};
    assign byteWord  = word_i >> byteShift;
    assign halfWord  = word_i >> halfShift;
    assign byteVal   = byteWord[BYTE_W-1:0];
    assign halfVal   = halfWord[HALF_W-1:0];
    assign byteMask  = 32'h0000_00FF << byteShift;
    assign halfMask  = 32'h0000_FFFF << halfShift;

    // Select the addressed lane and extend it to a full load result.
    always_comb begin
        loadData_o = 32'h0;
        case (funct3_i)
            F3_B:    loadData_o = {{24{byteVal[7]}}, byteVal};
            F3_H:    loadData_o = {{16{halfVal[15]}}, halfVal};
            F3_W:    loadData_o = word_i;
            F3_BU:   loadData_o = {24'h0, byteVal};
            F3_HU:   loadData_o = {16'h0, halfVal};
            default: loadData_o = 32'h0;
        endcase
    end

    // Overlay the low byte/half of the store data onto the old word.
    always_comb begin
        mergeData_o = word_i;
        case (funct3_i)
            F3_B: mergeData_o = (word_i & ~byteMask) | ({24'h0, wdata_i[7:0]} << byteShift);
            F3_H: mergeData_o = (word_i & ~halfMask) | ({16'h0, wdata_i[15:0]} << halfShift);
            F3_W: mergeData_o = wdata_i;
            default: mergeData_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/halfword access on a word-only memory.
// Every access reads the word first (uniform timing); stores then write
// back the merged word in a single WRITE cycle.
// Optional build macro: MISALIGNED_ERR_EN turns misaligned half/word
// accesses into errors; without it the low address bits are ignored.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] memAdr,
    output logic [DATA_W-1:0] writeData,
    output logic              memWrite,
    input  logic [DATA_W-1:0] readData
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              illegal;
    logic [DATA_W-1:0] alignWord;
    logic [DATA_W-1:0] loadData;
    logic [DATA_W-1:0] mergeData;

    // Decide legality from the latched operands (size code, optionally alignment).
    always_comb begin
        illegal = !legalFunct3(we_q, funct3_q);
`ifdef MISALIGNED_ERR_EN
        illegal = illegal || misaligned(funct3_q, addr_q[1:0]);
`else
        illegal = illegal;
`endif
    end

    // In READ the load result comes straight from memory; later the captured word is merged.
    assign alignWord = (state_q == ST_READ) ? readData : word_q;

    lsu_lane_align u_align (
        .word_i      (alignWord),
        .wdata_i     (wdata_q),
        .lane_i      (addr_q[1:0]),
        .funct3_i    (funct3_q),
        .loadData_o  (loadData),
        .mergeData_o (mergeData)
    );

    // Next-state logic for the IDLE -> READ -> (WRITE) -> DONE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req) state_d = ST_READ;
            ST_READ:  state_d = (we_q && !illegal) ? ST_WRITE : ST_DONE;
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, operand latches, captured memory word, error flag and load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req) begin
                addr_q   <= addr;
                funct3_q <= funct3;
                we_q     <= we;
                wdata_q  <= wdata;
                err_q    <= 1'b0;
            end
            if (state_q == ST_READ) begin
                word_q <= readData;
                err_q  <= illegal;
                if (!we_q && !illegal) begin
                    rdata_q <= loadData;
                end
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_DONE) && err_q;
    assign rdata     = rdata_q;
    assign memWrite  = (state_q == ST_WRITE) && !rst;
    assign writeData = mergeData;
    assign memAdr    = ((state_q == ST_READ) || (state_q == ST_WRITE)) ?
                       {addr_q[ADDR_W-1:2], 2'b00} : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a small
// word memory model attached to memAdr/readData/writeData/memWrite.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] memAdr;
    logic [31:0] writeData;
    logic        memWrite;
    logic [31:0] readData;

    logic [31:0] mem [0:255];

    int vectors = 0;
    int miscompares = 0;
    int writeCount = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          writes;
        logic [31:0] word;
    } exp_t;

    exp_t scoreboard[$];

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .memAdr    (memAdr),
        .writeData (writeData),
        .memWrite  (memWrite),
        .readData  (readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: combinational read, whole-word write on the strobe.
    assign readData = mem[memAdr[9:2]];
    always @(posedge clk) begin
        if (memWrite) mem[memAdr[9:2]] <= writeData;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Every write strobe must target the test word.
    always @(negedge clk) begin
        if (memWrite) begin
            writeCount++;
            checkOutput("memAdr_on_write", memAdr, 32'h0000_0100);
        end
    end

    task automatic applyStimulus(input string tag, input logic isWe, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] expR, input logic expE, input int expLat,
                                 input int expWrites, input logic [31:0] expWord, input bit pulseAgain);
        exp_t e;
        int k;
        int w0;
        bit got;
        e.rdata = expR; e.err = expE; e.lat = expLat; e.writes = expWrites; e.word = expWord;
        scoreboard.push_back(e);
        w0 = writeCount;
        req = 1'b1; we = isWe; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk);
        @(negedge clk);
        k = 1;
        got = 0;
        while (k <= 8 && !got) begin
            if (pulseAgain && k == 1) begin
                req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0200;
            end else begin
                req = 1'b0;
            end
            if (done) got = 1;
            else begin
                @(posedge clk);
                @(negedge clk);
                k++;
            end
        end
        req = 1'b0;
        e = scoreboard.pop_front();
        if (!got) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({tag, "_latency"}, k, e.lat);
            checkOutput({tag, "_err"}, {31'h0, err}, {31'h0, e.err});
            checkOutput({tag, "_rdata"}, rdata, e.rdata);
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_doneAfter"}, {31'h0, done}, 32'd0);
        checkOutput({tag, "_busyAfter"}, {31'h0, busy}, 32'd0);
        checkOutput({tag, "_writes"}, writeCount - w0, e.writes);
        checkOutput({tag, "_word"}, mem[64], e.word);
    endtask

    logic [31:0] prevR;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[64] = 32'h8081_7F42;
        rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", {31'h0, busy}, 32'd0);
        checkOutput("reset_done", {31'h0, done}, 32'd0);
        checkOutput("reset_err", {31'h0, err}, 32'd0);
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_memWrite", {31'h0, memWrite}, 32'd0);
        checkOutput("reset_memAdr", memAdr, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus("lb_101",  1'b0, 3'b000, 32'h101, 32'h0, 32'h0000_007F, 1'b0, 2, 0, 32'h8081_7F42, 0);
        applyStimulus("lb_103",  1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0, 32'h8081_7F42, 0);
        applyStimulus("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h0000_0080, 1'b0, 2, 0, 32'h8081_7F42, 0);
        applyStimulus("lh_102",  1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF_8081, 1'b0, 2, 0, 32'h8081_7F42, 0);
        applyStimulus("lw_100",  1'b0, 3'b010, 32'h100, 32'h0, 32'h8081_7F42, 1'b0, 2, 0, 32'h8081_7F42, 0);
        applyStimulus("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h0000_8081, 1'b0, 2, 0, 32'h8081_7F42, 0);
`ifdef MISALIGNED_ERR_EN
        applyStimulus("lw_102",  1'b0, 3'b010, 32'h102, 32'h0, 32'h0000_8081, 1'b1, 2, 0, 32'h8081_7F42, 0);
        prevR = 32'h0000_8081;
`else
        applyStimulus("lw_102",  1'b0, 3'b010, 32'h102, 32'h0, 32'h8081_7F42, 1'b0, 2, 0, 32'h8081_7F42, 0);
        prevR = 32'h8081_7F42;
`endif
        applyStimulus("ld_f3_011", 1'b0, 3'b011, 32'h100, 32'h0, prevR, 1'b1, 2, 0, 32'h8081_7F42, 0);
        applyStimulus("sb_102", 1'b1, 3'b000, 32'h102, 32'hAAAA_AA55, prevR, 1'b0, 3, 1, 32'h8055_7F42, 0);
        mem[64] = 32'h8081_7F42;
        applyStimulus("sh_100", 1'b1, 3'b001, 32'h100, 32'h1234_BEEF, prevR, 1'b0, 3, 1, 32'h8081_BEEF, 0);
        mem[64] = 32'h8081_7F42;
        applyStimulus("st_f3_100", 1'b1, 3'b100, 32'h100, 32'h1234_5678, prevR, 1'b1, 2, 0, 32'h8081_7F42, 0);
        applyStimulus("lbu_101_dup", 1'b0, 3'b100, 32'h101, 32'h0, 32'h0000_007F, 1'b0, 2, 0, 32'h8081_7F42, 1);
        applyStimulus("sw_100", 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0000_007F, 1'b0, 3, 1, 32'hDEAD_BEEF, 0);
        mem[64] = 32'h8081_7F42;

        // Reset landing in the WRITE cycle of an sb must suppress the write.
        req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h102; wdata = 32'h1111_1111;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstw_inWrite_busy", {31'h0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstw_memWrite", {31'h0, memWrite}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstw_busy", {31'h0, busy}, 32'd0);
        checkOutput("rstw_rdata", rdata, 32'h0);
        checkOutput("rstw_memAdr", memAdr, 32'h0);
        checkOutput("rstw_word", mem[64], 32'h8081_7F42);

        applyStimulus("lb_100_post", 1'b0, 3'b000, 32'h100, 32'h0, 32'h0000_0042, 1'b0, 2, 0, 32'h8081_7F42, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
